// File: rtl/norm_sqrt.sv
// norm_sqrt: iterative floor(sqrt(a^2+b^2)) using one restoring root bit per cycle
module norm_sqrt #(
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              fin,
    output logic [DATA_W-1:0] result
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, ROOT = 2'd2, DONE = 2'd3;

    logic [1:0]                state;
    logic signed [DATA_W-1:0]  xa, xb;
    logic [2*DATA_W-1:0]       rad;
    logic [DATA_W+1:0]         rem;
    logic [DATA_W-1:0]         root;
    logic [CW-1:0]             cnt;

    logic signed [2*DATA_W-1:0] ea, eb;
    logic [2*DATA_W-1:0]        sq_sum;
    logic [DATA_W+1:0]          rem_sh, trial, rem_nx;
    logic                       ge;
    logic [DATA_W-1:0]          root_nx;
    logic                       ready;

    // Sign-extended squares are non-negative; their sum peaks at 2^(2*DATA_W-1) and fits unsigned.
    assign ea      = xa;
    assign eb      = xb;
    assign sq_sum  = $unsigned(ea * ea) + $unsigned(eb * eb);
    assign rem_sh  = (rem << 2) | {{DATA_W{1'b0}}, rad[2*DATA_W-1 -: 2]};
    assign trial   = {root, 2'b01};
    assign ge      = rem_sh >= trial;
    assign rem_nx  = ge ? rem_sh - trial : rem_sh;
    assign root_nx = {root[DATA_W-2:0], ge};
    assign ready   = (state == IDLE) || (state == DONE);
    assign busy    = (state == LOAD) || (state == ROOT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            fin    <= 1'b0;
            result <= '0;
            xa     <= '0;
            xb     <= '0;
            rad    <= '0;
            rem    <= '0;
            root   <= '0;
            cnt    <= '0;
        end else begin
            fin <= 1'b0;
            if (ready) begin
                state <= IDLE;
                if (en) begin
                    xa    <= a;
                    xb    <= b;
                    state <= LOAD;
                end
            end else if (state == LOAD) begin
                rad   <= sq_sum;
                rem   <= '0;
                root  <= '0;
                cnt   <= '0;
                state <= ROOT;
            end else begin
                rad  <= rad << 2;
                rem  <= rem_nx;
                root <= root_nx;
                cnt  <= cnt + 1'b1;
                if (cnt == LAST) begin
                    result <= root_nx;
                    fin    <= 1'b1;
                    state  <= DONE;
                end
            end
        end
    end
endmodule

// File: doc/norm_sqrt.md
Name: norm_sqrt

Overview:
- Iterative Euclidean-magnitude unit for the QR engine: computes r = floor(sqrt(a^2 + b^2)) for one pair of signed samples.
- Sits directly upstream of the Divide stage. It supplies the norm used as the divisor for the Givens cos/sin terms (c = a/r, s = b/r).
- Uses the same en/fin handshake as Divide.
- Computes one root bit per cycle with a restoring square-root algorithm.

Parameters:
- DATA_W, 16, width of signed inputs a and b and of the unsigned result. The radicand is 2*DATA_W bits. Iterations = DATA_W.

Ports:
- i_clk  input  1  clock, rising-edge.
- i_rst  input  1  reset, synchronous, active-high.
- en  input  1  start request, sampled only when the block is ready.
- a  input  DATA_W  signed operand x, sampled on the accepting edge.
- b  input  DATA_W  signed operand y, sampled on the accepting edge.
- busy  output  1  high while a computation is in flight (LOAD or ROOT).
- fin  output  1  one-cycle pulse: result is valid and updated.
- result  output  DATA_W  unsigned floor(sqrt(a^2+b^2)), held until the next fin.

Behaviour:
- Reset values (i_rst high at a rising edge): state=IDLE, fin=0, busy=0, result=0, internal radicand/remainder/root/counter=0. Reset overrides every other event, including mid-computation. An aborted computation never produces fin.
- States: IDLE, LOAD, ROOT, DONE.
- IDLE: en=1 at edge k → latch a, b; go to LOAD.
- LOAD (edge k+1):
  - radicand = a*a + b*b, computed as full-width signed products summed into an unsigned 2*DATA_W register.
  - Max value is 2^(2*DATA_W-1) (a=b=-2^(DATA_W-1)), so the sum never overflows.
  - Clear remainder and root; cnt=0; go to ROOT.
- ROOT (edges k+2 .. k+17 for DATA_W=16), one iteration per edge:
  - rem' = (rem<<2) | next two MSBs of radicand (shift radicand left by 2).
  - trial = (root<<2)|1.
  - If rem' >= trial: rem = rem' - trial, root = (root<<1)|1. Otherwise rem = rem', root = root<<1.
  - rem is DATA_W+2 bits wide and must never truncate.
  - After iteration cnt=DATA_W-1, register result=root and fin=1 on that same edge; go to DONE.
- DONE: lasts one cycle, with fin=1 and busy=0.
  - If en=1, accept new operands exactly as from IDLE and go to LOAD.
  - Otherwise go to IDLE.
  - fin drops to 0 on the next edge in either case.
- Latency: fin is observed high in the cycle after edge k+DATA_W+1 (edge k+17 at default).
- Throughput: with en held high, one result every DATA_W+2 = 18 cycles.
- busy=1 exactly in LOAD and ROOT. en is ignored while busy=1, and a/b changes during busy have no effect.
- result changes only on the edge that sets fin=1, or on reset.
- Sign handling: squares are sign-independent. (-x, y), (x, -y) and (y, x) produce identical results.
- Exactness: result r satisfies r^2 <= a^2+b^2 < (r+1)^2. Final rem = radicand - r^2.

Test Plan:
- Reset then a=-5066, b=10028, en pulsed one cycle → fin high exactly 17 edges after the accepting edge; result=11234 (radicand 126225140); result then stable while en=0.
- a=3,b=4 → 5. a=0,b=0 → 0. a=0,b=-1 → 1. a=-4,b=3 → 5, identical to (3,4).
- Corner case a=b=-32768 → radicand 2147483648, result=46340, no overflow. Also a=32767,b=0 → 32767.
- en held high with operands (3,4), then (5066,10028) applied during busy → the first result is 5. Operands present on the DONE cycle are accepted there (no IDLE gap), so fin pulses every 18 cycles. The in-busy change is ignored for the first run.
- Reset mid-op: start (3,4), assert i_rst at edge k+8 for one cycle → fin never pulses, result=0, busy=0. A fresh en afterwards gives the normal latency and the correct result.
- Random signed (a,b), ≥1000 vectors, checked against a reference floor sqrt → exact match; rem invariant r^2 <= s < (r+1)^2 holds.
